// File: rtl/duty_slew_if.sv
// Control-side bundle between the slew controller and its environment:
// raw switch word and hold in, duty word and status out.
interface duty_slew_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] target_in;
    logic             hold;
    logic [WIDTH-1:0] duty_out;
    logic [WIDTH-1:0] target_q;
    logic             busy;
    logic             settled;

    modport master (
        output target_in, hold,
        input  duty_out, target_q, busy, settled
    );

    modport slave (
        input  target_in, hold,
        output duty_out, target_q, busy, settled
    );
endinterface

// File: rtl/duty_slew_ctrl.sv
// Synchronizes and debounces a raw switch word into a target, then slews the
// PWM duty word toward it in bounded steps at a prescaled tick rate.
module duty_slew_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int TICK_DIV      = 256,
    parameter int STEP          = 1
) (
    input  logic       clk,
    input  logic       rst,
    duty_slew_if.slave bus
);
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(TICK_DIV - 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_cand;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_target_q;
    logic [PRE_W-1:0] r_presc;
    logic [WIDTH-1:0] r_duty;
    logic             r_settled;
    state_t           r_state;

    logic [WIDTH-1:0] w_sync_val;
    logic             w_tick;
    logic [WIDTH:0]   w_up_diff;
    logic [WIDTH:0]   w_dn_diff;
    state_t           w_state_next;
    logic [WIDTH-1:0] w_duty_next;
    logic             w_settle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= bus.target_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sync_val = r_sync[SYNC_STAGES-1];

    // Counter saturates once the candidate is accepted, so target_q keeps
    // being refreshed with the same value while the input stays steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand     <= '0;
            r_cnt      <= '0;
            r_target_q <= '0;
        end else if (w_sync_val != r_cand) begin
            r_cand <= w_sync_val;
            r_cnt  <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_target_q <= r_cand;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   r_presc <= '0;
        else if (r_presc == PRE_MAX) r_presc <= '0;
        else                       r_presc <= r_presc + 1'b1;
    end

    assign w_tick    = (r_presc == PRE_MAX);
    assign w_up_diff = {1'b0, r_target_q} - {1'b0, r_duty};
    assign w_dn_diff = {1'b0, r_duty} - {1'b0, r_target_q};

    // Final step lands exactly on the target, so the duty can neither
    // overshoot nor wrap past either end of the range.
    always_comb begin
        w_state_next = r_state;
        w_duty_next  = r_duty;
        w_settle     = 1'b0;
        if (w_tick && !bus.hold) begin
            case (r_state)
                IDLE: begin
                    if (r_target_q > r_duty)      w_state_next = UP;
                    else if (r_target_q < r_duty) w_state_next = DOWN;
                end
                UP: begin
                    if (r_target_q < r_duty) begin
                        w_state_next = DOWN;
                    end else if (w_up_diff <= STEP_EXT) begin
                        w_duty_next  = r_target_q;
                        w_state_next = IDLE;
                        w_settle     = 1'b1;
                    end else begin
                        w_duty_next = r_duty + STEP_W;
                    end
                end
                DOWN: begin
                    if (r_target_q > r_duty) begin
                        w_state_next = UP;
                    end else if (w_dn_diff <= STEP_EXT) begin
                        w_duty_next  = r_target_q;
                        w_state_next = IDLE;
                        w_settle     = 1'b1;
                    end else begin
                        w_duty_next = r_duty - STEP_W;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_duty    <= '0;
            r_settled <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_duty    <= w_duty_next;
            r_settled <= w_settle;
        end
    end

    assign bus.duty_out = r_duty;
    assign bus.target_q = r_target_q;
    assign bus.busy     = (r_state != IDLE);
    assign bus.settled  = r_settled;
endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Directed bench for duty_slew_ctrl: a STEP=1 instance for the main scenarios
// and a STEP=3 instance for non-dividing steps and range boundaries.
module tb_duty_slew_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   settled_cnt = 0;
    bit   busy_mon = 1'b0;
    bit   busy_seen = 1'b0;

    duty_slew_if #(.WIDTH(8)) bus  ();
    duty_slew_if #(.WIDTH(8)) bus3 ();

    duty_slew_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4), .TICK_DIV(4), .STEP(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );
    duty_slew_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .STABLE_CYCLES(4), .TICK_DIV(4), .STEP(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.settled) settled_cnt++;
        if (busy_mon && bus.busy) busy_seen = 1'b1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_change(input bit sel3, input logic [7:0] prev, input int limit,
                               output int cycles, output bit timeout);
        logic [7:0] cur;
        cycles  = 0;
        timeout = 1'b1;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            cur = sel3 ? bus3.duty_out : bus.duty_out;
            if (cur !== prev) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_settled3(input int limit, output bit timeout);
        timeout = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (bus3.settled === 1'b1) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.target_in  = 8'h00; bus.hold  = 1'b0;
        bus3.target_in = 8'h00; bus3.hold = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.duty_out !== 8'h00) begin errors++; $display("FAIL reset_duty got=%h exp=00", bus.duty_out); end
        checks++; if (bus.target_q !== 8'h00) begin errors++; $display("FAIL reset_target got=%h exp=00", bus.target_q); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.settled !== 1'b0) begin errors++; $display("FAIL reset_settled got=%b exp=0", bus.settled); end
        rst = 1'b0;
        $display("reset: duty=%h target_q=%h busy=%b", bus.duty_out, bus.target_q, bus.busy);
    endtask

    task automatic test_rise();
        int c; bit to; int base;
        bus.target_in = 8'h10;
        repeat (6) @(negedge clk);
        checks++; if (bus.target_q !== 8'h00) begin errors++; $display("FAIL rise_target_early got=%h exp=00", bus.target_q); end
        @(negedge clk);
        checks++; if (bus.target_q !== 8'h10) begin errors++; $display("FAIL rise_target_lat7 got=%h exp=10", bus.target_q); end
        base = settled_cnt;
        for (int v = 1; v <= 16; v++) begin
            wait_change(1'b0, 8'(v - 1), 16, c, to);
            checks++;
            if (to || bus.duty_out !== 8'(v)) begin
                errors++; $display("FAIL rise_step%0d got=%h exp=%h timeout=%b", v, bus.duty_out, 8'(v), to);
            end
            if (v > 1) begin
                checks++; if (c !== 4) begin errors++; $display("FAIL rise_interval%0d got=%0d exp=4", v, c); end
            end
            $display("rise: duty=%h after %0d cycles busy=%b settled=%b", bus.duty_out, c, bus.busy, bus.settled);
        end
        checks++; if (bus.settled !== 1'b1) begin errors++; $display("FAIL rise_settled got=%b exp=1", bus.settled); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rise_busy_drop got=%b exp=0", bus.busy); end
        repeat (10) @(negedge clk);
        checks++; if (settled_cnt - base !== 1) begin errors++; $display("FAIL rise_settled_count got=%0d exp=1", settled_cnt - base); end
        checks++; if (bus.duty_out !== 8'h10) begin errors++; $display("FAIL rise_hold_final got=%h exp=10", bus.duty_out); end
    endtask

    task automatic test_debounce();
        bus.target_in = 8'h00;
        do_reset();
        busy_seen = 1'b0;
        busy_mon  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.target_in = (i % 2 == 0) ? 8'h20 : 8'h00;
            repeat (2) @(negedge clk);
        end
        bus.target_in = 8'h00;
        repeat (20) @(negedge clk);
        busy_mon = 1'b0;
        checks++; if (bus.target_q !== 8'h00) begin errors++; $display("FAIL debounce_target got=%h exp=00", bus.target_q); end
        checks++; if (bus.duty_out !== 8'h00) begin errors++; $display("FAIL debounce_duty got=%h exp=00", bus.duty_out); end
        checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL debounce_busy got=%b exp=0", busy_seen); end
        $display("debounce: target_q=%h duty=%h busy_seen=%b", bus.target_q, bus.duty_out, busy_seen);
    endtask

    task automatic test_reversal();
        int c; bit to;
        logic [7:0] exp_dn [5] = '{8'h07, 8'h06, 8'h05, 8'h04, 8'h03};
        logic [7:0] prev;
        bus.target_in = 8'h00;
        do_reset();
        bus.target_in = 8'h40;
        for (int v = 1; v <= 7; v++) wait_change(1'b0, 8'(v - 1), 16, c, to);
        checks++; if (bus.duty_out !== 8'h07) begin errors++; $display("FAIL rev_reach7 got=%h exp=07", bus.duty_out); end
        bus.target_in = 8'h03;
        wait_change(1'b0, 8'h07, 16, c, to);
        checks++; if (to || bus.duty_out !== 8'h08) begin errors++; $display("FAIL rev_reach8 got=%h exp=08", bus.duty_out); end
        $display("reversal: duty=%h", bus.duty_out);
        prev = 8'h08;
        for (int i = 0; i < 5; i++) begin
            wait_change(1'b0, prev, 16, c, to);
            checks++;
            if (to || bus.duty_out !== exp_dn[i]) begin
                errors++; $display("FAIL rev_down%0d got=%h exp=%h", i, bus.duty_out, exp_dn[i]);
            end
            checks++;
            if (c !== ((i == 0) ? 8 : 4)) begin
                errors++; $display("FAIL rev_interval%0d got=%0d exp=%0d", i, c, (i == 0) ? 8 : 4);
            end
            prev = bus.duty_out;
            $display("reversal: duty=%h after %0d cycles busy=%b settled=%b", bus.duty_out, c, bus.busy, bus.settled);
        end
        checks++; if (bus.settled !== 1'b1) begin errors++; $display("FAIL rev_settled got=%b exp=1", bus.settled); end
    endtask

    task automatic test_step3();
        int c; bit to;
        logic [7:0] exp_up [4] = '{8'h03, 8'h06, 8'h09, 8'h0A};
        logic [7:0] prev;
        bus3.target_in = 8'h00;
        do_reset();
        bus3.target_in = 8'h0A;
        prev = 8'h00;
        for (int i = 0; i < 4; i++) begin
            wait_change(1'b1, prev, 24, c, to);
            checks++;
            if (to || bus3.duty_out !== exp_up[i]) begin
                errors++; $display("FAIL step3_up%0d got=%h exp=%h", i, bus3.duty_out, exp_up[i]);
            end
            prev = bus3.duty_out;
            $display("step3: duty=%h", bus3.duty_out);
        end
        checks++; if (bus3.settled !== 1'b1) begin errors++; $display("FAIL step3_settled_0a got=%b exp=1", bus3.settled); end
        bus3.target_in = 8'hFD;
        wait_settled3(600, to);
        checks++; if (to || bus3.duty_out !== 8'hFD) begin errors++; $display("FAIL step3_reach_fd got=%h exp=fd", bus3.duty_out); end
        bus3.target_in = 8'hFF;
        wait_change(1'b1, 8'hFD, 24, c, to);
        checks++; if (to || bus3.duty_out !== 8'hFF) begin errors++; $display("FAIL step3_ff got=%h exp=ff", bus3.duty_out); end
        repeat (12) @(negedge clk);
        checks++; if (bus3.duty_out !== 8'hFF) begin errors++; $display("FAIL step3_nowrap got=%h exp=ff", bus3.duty_out); end
        $display("step3: duty=%h at top", bus3.duty_out);
        bus3.target_in = 8'h02;
        wait_settled3(600, to);
        checks++; if (to || bus3.duty_out !== 8'h02) begin errors++; $display("FAIL step3_reach_02 got=%h exp=02", bus3.duty_out); end
        bus3.target_in = 8'h00;
        wait_change(1'b1, 8'h02, 24, c, to);
        checks++; if (to || bus3.duty_out !== 8'h00) begin errors++; $display("FAIL step3_zero got=%h exp=00", bus3.duty_out); end
        repeat (12) @(negedge clk);
        checks++; if (bus3.duty_out !== 8'h00) begin errors++; $display("FAIL step3_nounderflow got=%h exp=00", bus3.duty_out); end
        $display("step3: duty=%h at bottom", bus3.duty_out);
    endtask

    task automatic test_hold();
        int c; bit to; bit frozen_ok;
        bus.target_in = 8'h00;
        do_reset();
        bus.target_in = 8'h10;
        for (int v = 1; v <= 5; v++) wait_change(1'b0, 8'(v - 1), 16, c, to);
        checks++; if (bus.duty_out !== 8'h05) begin errors++; $display("FAIL hold_reach5 got=%h exp=05", bus.duty_out); end
        bus.hold  = 1'b1;
        frozen_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.duty_out !== 8'h05 || bus.busy !== 1'b1) frozen_ok = 1'b0;
        end
        checks++; if (frozen_ok !== 1'b1) begin errors++; $display("FAIL hold_frozen got=%h busy=%b exp=05 busy=1", bus.duty_out, bus.busy); end
        bus.hold = 1'b0;
        wait_change(1'b0, 8'h05, 16, c, to);
        checks++; if (to || bus.duty_out !== 8'h06) begin errors++; $display("FAIL hold_resume got=%h exp=06", bus.duty_out); end
        checks++; if (c !== 4) begin errors++; $display("FAIL hold_resume_phase got=%0d exp=4", c); end
        $display("hold: resumed duty=%h after %0d cycles", bus.duty_out, c);
    endtask

    task automatic test_async_reset();
        int c; bit to; bit ok;
        bus.target_in = 8'h00;
        do_reset();
        bus.target_in = 8'h10;
        for (int v = 1; v <= 9; v++) wait_change(1'b0, 8'(v - 1), 16, c, to);
        checks++; if (bus.duty_out !== 8'h09) begin errors++; $display("FAIL areset_reach9 got=%h exp=09", bus.duty_out); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.duty_out !== 8'h00) begin errors++; $display("FAIL areset_duty got=%h exp=00", bus.duty_out); end
        checks++; if (bus.target_q !== 8'h00) begin errors++; $display("FAIL areset_target got=%h exp=00", bus.target_q); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.settled !== 1'b0) begin errors++; $display("FAIL areset_settled got=%b exp=0", bus.settled); end
        $display("areset: duty=%h target_q=%h busy=%b", bus.duty_out, bus.target_q, bus.busy);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        checks++; if (bus.target_q !== 8'h10) begin errors++; $display("FAIL areset_target_again got=%h exp=10", bus.target_q); end
        ok = 1'b1;
        for (int v = 1; v <= 16; v++) begin
            wait_change(1'b0, 8'(v - 1), 16, c, to);
            if (to || bus.duty_out !== 8'(v)) ok = 1'b0;
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL areset_rerise got=%h exp=10 full sequence", bus.duty_out); end
        checks++; if (bus.settled !== 1'b1) begin errors++; $display("FAIL areset_settled_end got=%b exp=1", bus.settled); end
        $display("areset: re-rise ended at duty=%h", bus.duty_out);
    endtask

    initial begin
        test_reset();
        test_rise();
        test_debounce();
        test_reversal();
        test_step3();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
